cle_challenge_seq: RTL

- Bus-side sequencer that sits directly upstream of the CLE386 lock GAL.
- Drives the lock's qualified read cycles (SSER, BA13, BA12, BA7..BA4, BR_W) with a programmed sequence of challenge nibbles.
- Captures the serial SDRD bit the lock returns on each cycle and assembles the bits into a response word.
- Compares the response against an expected value and reports pass/fail to the host controller.

---
 rtl/cle_pkg.sv | 25 ++
 rtl/cle_gap_timer.sv | 27 ++
 rtl/cle_challenge_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cle_pkg.sv
// Shared definitions for the CLE386 challenge sequencer: FSM states, lock
// address-window constants and the run-length helper.
package cle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP,
    ST_FINISH
  } state_t;

  // Address window that qualifies a lock read, and the values the bus rests at.
  localparam logic       BA13_WINDOW = 1'b0;
  localparam logic       BA12_WINDOW = 1'b1;
  localparam logic       BA13_IDLE   = 1'b1;
  localparam logic       BA12_IDLE   = 1'b0;
  localparam logic [3:0] BA_LO_IDLE  = 4'h0;

  // Clocks from the start cycle through the done pulse, both inclusive.
  function automatic int run_length(input int n_steps, input int gap);
    return 1 + n_steps * (2 + gap) + 1;
  endfunction

endpackage

// File: rtl/cle_gap_timer.sv
// Loadable down-counter that times the idle gap between lock select strobes.
module cle_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/cle_challenge_seq.sv
// Drives a programmed sequence of qualified reads into the CLE386 lock, collects
// the SDRD bits into a response word and compares it with the expected word.
module cle_challenge_seq #(
  parameter int N_STEPS = 8,
  parameter int GAP     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*N_STEPS-1:0]   challenge,
  input  logic [N_STEPS-1:0]     expected,
  output logic                   sser_n,
  output logic                   ba13,
  output logic                   ba12,
  output logic [3:0]             ba_lo,
  output logic                   br_w,
  input  logic                   sdrd,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_STEPS-1:0]     resp
);

  import cle_pkg::*;

  localparam int         STEP_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  state_t             state_reg;
  logic [STEP_W-1:0]  step_reg;
  logic [STEP_W-1:0]  step_inc;
  logic               gap_load;
  logic               gap_dec;
  logic               gap_zero;

  assign step_inc = step_reg + 1'b1;
  assign gap_load = (state_reg == ST_STROBE);
  assign gap_dec  = (state_reg == ST_GAP);

  // The sequencer only ever reads the lock.
  assign br_w = 1'b1;

  cle_gap_timer #(
    .W (4)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      sser_n    <= 1'b1;
      ba13      <= BA13_IDLE;
      ba12      <= BA12_IDLE;
      ba_lo     <= BA_LO_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      resp      <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SETUP;
            step_reg  <= '0;
            resp      <= '0;
            busy      <= 1'b1;
            ba_lo     <= challenge[3:0];
            ba13      <= BA13_WINDOW;
            ba12      <= BA12_WINDOW;
          end
        end
        ST_SETUP: begin
          sser_n    <= 1'b0;
          state_reg <= ST_STROBE;
        end
        ST_STROBE: begin
          // The lock advances on this same edge, so this is the pre-advance bit.
          resp[step_reg] <= sdrd;
          sser_n         <= 1'b1;
          ba13           <= BA13_IDLE;
          ba12           <= BA12_IDLE;
          ba_lo          <= BA_LO_IDLE;
          state_reg      <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_zero) begin
            if (step_reg == LAST_STEP) begin
              state_reg <= ST_FINISH;
              done      <= 1'b1;
              busy      <= 1'b0;
              pass      <= (resp == expected);
            end else begin
              step_reg  <= step_inc;
              ba_lo     <= challenge[4*int'(step_inc) +: 4];
              ba13      <= BA13_WINDOW;
              ba12      <= BA12_WINDOW;
              state_reg <= ST_SETUP;
            end
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
